// File: rtl/nn_fpga_mul_pkg.sv
// Shared defaults and helpers for the time-shared multiplier arbiter.
package nn_fpga_mul_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int A_W_DEF     = 4;
    localparam int B_W_DEF     = 11;
    localparam int P_W_DEF     = 13;
    localparam int CNT_W_DEF   = 16;
    localparam int MAX_REQ     = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // First valid requester at or after ptr, wrapping at n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input int ptr,
                                      input int n);
        pick_t r;
        int    j;
        r = '0;
        j = 0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!r.found && valid[j[3:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_fpga_mul_arbiter_umul.sv
// Combinational unsigned multiply returning the full-width product.
module nn_fpga_umul_core
    import nn_fpga_mul_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF
) (
    input  logic [A_W-1:0]     a_i,
    input  logic [B_W-1:0]     b_i,
    output logic [A_W+B_W-1:0] p_o
);

    assign p_o = (A_W+B_W)'(a_i) * (A_W+B_W)'(b_i);

endmodule

// File: rtl/nn_fpga_mul_arbiter.sv
// Round-robin arbiter feeding one shared multiplier through a
// two-stage (operand, result) pipeline with full backpressure.
module nn_fpga_mul_arbiter
    import nn_fpga_mul_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int A_W     = A_W_DEF,
    parameter int B_W     = B_W_DEF,
    parameter int P_W     = P_W_DEF,
    parameter int ID_W    = id_w(NUM_REQ),
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [P_W-1:0]         rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_ovf,
    output logic [CNT_W-1:0]       issue_cnt
);

    logic              s1_valid_q, s1_valid_d;
    logic [A_W-1:0]    s1_a_q, s1_a_d;
    logic [B_W-1:0]    s1_b_q, s1_b_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;

    logic              s2_valid_q, s2_valid_d;
    logic [P_W-1:0]    s2_data_q, s2_data_d;
    logic [ID_W-1:0]   s2_id_q, s2_id_d;
    logic              s2_ovf_q, s2_ovf_d;

    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [MAX_REQ-1:0] valid_ext;
    pick_t             pick;
    logic              s1_adv, s2_adv, accept;
    int                nxt;

    logic [A_W+B_W-1:0] full;
    logic [P_W-1:0]     prod_lo;
    logic               prod_ovf;

    assign s2_adv = !s2_valid_q || rsp_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        pick                     = rr_pick(valid_ext, int'(rr_ptr_q), NUM_REQ);
    end

    // Grant is also gated by reset so nothing is offered while ap_rst is high.
    assign accept = pick.found && s1_adv && !ap_rst;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (pick.idx == 4'(i));
        end
    end

    nn_fpga_umul_core #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_umul (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .p_o (full)
    );

    if (P_W < A_W + B_W) begin : g_trunc
        assign prod_lo  = full[P_W-1:0];
        assign prod_ovf = |full[A_W+B_W-1:P_W];
    end else begin : g_wide
        assign prod_lo  = P_W'(full);
        assign prod_ovf = 1'b0;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        nxt        = int'(pick.idx) + 1;
        if (nxt >= NUM_REQ) begin
            nxt = 0;
        end
        if (s1_adv) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_a_d   = req_a[int'(pick.idx)*A_W +: A_W];
            s1_b_d   = req_b[int'(pick.idx)*B_W +: B_W];
            s1_id_d  = ID_W'(pick.idx);
            rr_ptr_d = ID_W'(nxt);
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        s2_ovf_d   = s2_ovf_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = prod_lo;
            s2_id_d    = s1_id_q;
            s2_ovf_d   = prod_ovf;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            s2_ovf_q   <= 1'b0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            s2_ovf_q   <= s2_ovf_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_data  = s2_data_q;
    assign rsp_id    = s2_id_q;
    assign rsp_ovf   = s2_ovf_q;
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_nn_fpga_mul_arbiter.sv
// Directed bench for the shared-multiplier arbiter.
module tb_nn_fpga_mul_arbiter;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [43:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [12:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ovf;
    logic [15:0] issue_cnt;

    int total = 0;
    int bad   = 0;

    int a_tab [4] = '{1, 2, 3, 4};
    int b_tab [4] = '{100, 101, 102, 103};
    int p_tab [4] = '{100, 202, 306, 412};

    always #5 ap_clk = ~ap_clk;

    nn_fpga_mul_arbiter dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf),
        .issue_cnt (issue_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        #1;
    endtask

    task automatic load_table();
        for (int i = 0; i < 4; i++) begin
            req_a[i*4 +: 4]   = 4'(a_tab[i]);
            req_b[i*11 +: 11] = 11'(b_tab[i]);
        end
    endtask

    initial begin
        ap_rst    = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        #2;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_ovf", rsp_ovf, 0);
        chk("rst_cnt", issue_cnt, 0);
        req_valid = 4'h0;
        tick();
        ap_rst = 1'b0;
        #1;

        // basic product from requester 2
        req_valid       = 4'b0100;
        req_a[8 +: 4]   = 4'd7;
        req_b[22 +: 11] = 11'd1000;
        #1;
        chk("basic_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("basic_gone", req_ready, 0);
        chk("basic_lat1", rsp_valid, 0);
        chk("basic_cnt", issue_cnt, 1);
        tick();
        chk("basic_valid", rsp_valid, 1);
        chk("basic_data", rsp_data, 7000);
        chk("basic_id", rsp_id, 2);
        chk("basic_ovf", rsp_ovf, 0);

        // overflow: 15*2047 = 30705 -> 6129 low bits
        req_valid       = 4'b0100;
        req_a[8 +: 4]   = 4'd15;
        req_b[22 +: 11] = 11'd2047;
        #1;
        chk("ovf_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("ovf_bubble", rsp_valid, 0);
        tick();
        chk("ovf_valid", rsp_valid, 1);
        chk("ovf_data", rsp_data, 6129);
        chk("ovf_flag", rsp_ovf, 1);
        chk("ovf_cnt", issue_cnt, 2);

        // round robin, all active
        do_reset();
        load_table();
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) begin
                chk("rr_grant", req_ready, 4'b0001 << (k % 4));
            end
            if (k >= 2) begin
                chk("rr_rvalid", rsp_valid, 1);
                chk("rr_id", rsp_id, (k - 2) % 4);
                chk("rr_data", rsp_data, p_tab[(k - 2) % 4]);
            end
            if (k == 8) begin
                chk("rr_cnt", issue_cnt, 8);
            end
            tick();
        end
        chk("rr_drained", rsp_valid, 0);

        // backpressure from cycle 0
        do_reset();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        #1;
        chk("bp_g0", req_ready, 4'b0001);
        tick();
        chk("bp_g1", req_ready, 4'b0010);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("bp_stall_ready", req_ready, 0);
            chk("bp_stall_valid", rsp_valid, 1);
            chk("bp_stall_id", rsp_id, 0);
            chk("bp_stall_data", rsp_data, 100);
            chk("bp_stall_cnt", issue_cnt, 2);
            tick();
        end
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        #1;
        chk("bp_pop0_id", rsp_id, 0);
        tick();
        chk("bp_pop1_valid", rsp_valid, 1);
        chk("bp_pop1_id", rsp_id, 1);
        chk("bp_pop1_data", rsp_data, 202);
        tick();
        chk("bp_empty", rsp_valid, 0);
        chk("bp_cnt", issue_cnt, 2);

        // reset with both stages full
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("mr_full", rsp_valid, 1);
        chk("mr_cnt_pre", issue_cnt, 4);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("mr_valid", rsp_valid, 0);
        chk("mr_cnt", issue_cnt, 0);
        chk("mr_ready", req_ready, 0);
        ap_rst    = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("mr_first", req_ready, 4'b0001);
        req_valid = 4'h0;

        // idle: pointer holds, nothing emitted
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_valid", rsp_valid, 0);
        end
        req_valid = 4'hF;
        #1;
        chk("idle_ptr", req_ready, 4'b0001);
        req_valid = 4'h0;
        #1;

        // counter wrap with a single requester granted every cycle
        do_reset();
        req_valid = 4'b1000;
        #1;
        chk("single_grant", req_ready, 4'b1000);
        repeat (65535) @(posedge ap_clk);
        #1;
        chk("wrap_pre", issue_cnt, 16'hFFFF);
        chk("single_still", req_ready, 4'b1000);
        tick();
        chk("wrap_zero", issue_cnt, 0);
        req_valid = 4'h0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_fpga_mul_arbiter.md
Name: nn_fpga_mul_arbiter

Overview:
- Shares one unsigned A_W x B_W multiplier among NUM_REQ requesters, such as the hidden-layer MAC lanes ahead of the tanh stage.
- Round-robin arbitration with a per-requester valid/ready handshake on the operand side.
- Two-stage pipeline (operand register, result register) with full backpressure.
- Returns each product tagged with its requester ID, so a single multiplier serves all neurons of a layer.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- A_W, 4, width of operand A, unsigned.
- B_W, 11, width of operand B, unsigned.
- P_W, 13, result width; product is truncated to its low P_W bits.
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- CNT_W, 16, width of the issue counter.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*A_W  packed operand A; requester i at bits [i*A_W +: A_W].
- req_b  in  NUM_REQ*B_W  packed operand B; requester i at bits [i*B_W +: B_W].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  P_W  product, low P_W bits.
- rsp_id  out  ID_W  index of the requester that issued the operands.
- rsp_ovf  out  1  high when the truncated product bits were nonzero.
- issue_cnt  out  CNT_W  count of accepted requests; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high):
  - s1_valid=0, s2_valid=0, rr_ptr=0, issue_cnt=0.
  - Outputs: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0.
  - req_ready=0 while ap_rst is high.
- Stage control:
  - s2_adv = !s2_valid | rsp_ready.
  - s1_adv = !s1_valid | s2_adv.
- Arbitration (combinational):
  - Winner = first i with req_valid[i], scanning from rr_ptr upward with wrap.
  - req_ready[winner] = s1_adv; all other bits 0.
  - No valid request: req_ready=0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept: req_valid[w] & req_ready[w]. On the same edge:
  - S1 captures a, b and id=w; s1_valid=1.
  - rr_ptr = (w+1) mod NUM_REQ.
  - issue_cnt increments.
- No accept while s1_adv: s1_valid=0 and rr_ptr holds.
- S1 to S2 when s2_adv:
  - full = s1_a * s1_b, zero-extended to A_W+B_W bits.
  - rsp_data = full[P_W-1:0].
  - rsp_ovf = |full[A_W+B_W-1:P_W].
  - rsp_id = s1_id; s2_valid = s1_valid.
- Latency: accept edge to rsp_valid is exactly 2 cycles. Throughput is 1 result per cycle with rsp_ready held high.
- Backpressure: with rsp_ready low, at most 2 transactions are held (S1, S2). All req_ready stay 0 until rsp_ready rises. Held S2 outputs are stable while rsp_valid=1 and rsp_ready=0.
- Simultaneous events: a response pop and a new accept in the same cycle are legal and lose nothing.
- Single active requester: granted every cycle.
- All requesters active: grants cycle 0,1,...,NUM_REQ-1,0.
- Reset mid-operation: in-flight S1/S2 contents are discarded with no response emitted. The arbiter restarts at requester 0.

Decomposition:
- Shared package nn_fpga_mul_pkg: A_W, B_W, P_W and NUM_REQ defaults; ID_W derivation; a function for the round-robin priority pick.
- One sub-module, nn_fpga_umul_core: purely combinational unsigned A_W x B_W multiply returning the full A_W+B_W-bit product. The block instantiates it between S1 and S2, which keeps the multiplier swappable for a DSP-mapped variant.

Test Plan:
- Basic product: only req 2 valid, a=7, b=1000, rsp_ready=1.
  - req_ready[2]=1 for one cycle.
  - 2 cycles later: rsp_valid=1, rsp_data=7000, rsp_id=2, rsp_ovf=0, issue_cnt=1.
- Overflow: a=15, b=2047 (full product 30705) -> rsp_data=6129, rsp_ovf=1.
- Round robin: all 4 valid for 8 cycles with rsp_ready=1.
  - Accept order 0,1,2,3,0,1,2,3.
  - rsp_id sequence matches, delayed by 2 cycles; issue_cnt=8.
- Backpressure: all valid, rsp_ready=0 from cycle 0.
  - Exactly 2 accepts, then req_ready=0.
  - rsp_data/rsp_id stable while stalled.
  - After rsp_ready=1, results drain in order with none lost or duplicated.
- Reset mid-flight: assert ap_rst asynchronously with S1 and S2 full.
  - rsp_valid drops immediately and issue_cnt=0.
  - After release with all valid, the first grant goes to req 0.
- Idle and wrap: no req_valid for 10 cycles -> rr_ptr holds and rsp_valid stays 0. Preload to 2^16-1 accepts and issue one more -> issue_cnt=0.
